multicycle_seq: RTL and testbench

//  Multi-cycle control sequencer for the RV32I core. Steps one instruction at a time through FETCH/DECODE/EXEC/MEM/WB.

---
 rtl/multicycle_seq.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// multicycle_seq: multi-cycle control sequencer for an RV32I core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. One memory port
// is shared between instruction fetch and load/store. The block produces the
// IR/PC/register-file write enables, counts retired instructions, and halts in
// TRAP on an illegal opcode or when memory does not answer in time.
//
//  state  | meaning
//  FETCH  | read instruction word at PC, wait for mem_ready
//  DECODE | capture opcode, check legality
//  EXEC   | one ALU cycle; branches retire here
//  MEM    | load/store data access at ALU address, wait for mem_ready
//  WB     | register write-back and PC update
//  TRAP   | halted until reset, cause held
module multicycle_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd7;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] C_ILLEGAL = 2'b01;
    localparam logic [1:0] C_FETCH   = 2'b10;
    localparam logic [1:0] C_DATA    = 2'b11;

    // wait_cnt only has to reach TIMEOUT-1
    localparam int            WCW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'b0010011, 7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111: is_legal = 1'b1;
            default:                                        is_legal = 1'b0;
        endcase
    endfunction

    // Next-state, wait counter and trap cause; wait_cnt is zero unless we stay waiting
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        wait_d  = '0;
        cause_d = cause_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = C_FETCH;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (is_legal(opcode)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = C_ILLEGAL;
                end
            end
            S_EXEC: begin
                if (op_q == OP_LOAD || op_q == OP_STORE) begin
                    state_d = S_MEM;
                end else if (op_q == OP_BRANCH) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                    cause_d = C_DATA;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Per-state control outputs; the retire cycle is also the single PC update
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (op_q == OP_STORE);
                if (mem_ready && op_q == OP_STORE) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            default: ;
        endcase
    end

    // Retired-instruction counter wraps naturally at 2^CNT_W
    always_comb begin
        instret_d = instret_q + CNT_W'(retire);
    end

    // State registers; reset overrides any pending transition or retire
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            cause_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    assign instret    = instret_q;
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_seq.sv
// Testbench for multicycle_seq: randomized instruction stream with a
// scoreboard. The driver predicts each instruction's outcome from the
// opcode class and the memory wait it will apply; a monitor compares.
module tb_multicycle_seq;

    localparam int TO = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'd0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, retire;
    logic [CW-1:0] instret;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [2:0]    state;

    multicycle_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .retire(retire),
        .instret(instret), .trap(trap), .trap_cause(trap_cause), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_trap;
        logic [1:0]    cause;
        int            lat;
        bit            wb;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   model_cnt = 0;

    logic [6:0] legal [9] = '{7'h13, 7'h03, 7'h23, 7'h33, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_legal(input logic [6:0] o);
        foreach (legal[i]) if (legal[i] == o) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        chk("reset_state", state, 0);
        chk("reset_instret", instret, 0);
        chk("reset_trap", {trap, trap_cause}, 0);
        model_cnt = 0;
        rst = 1'b0;
    endtask

    // Issue one instruction: fw/mw are the number of unanswered cycles in FETCH/MEM
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw);
        exp_t e;
        bit   ls, br, st, done;
        int   fc, mc;
        ls = (op == 7'h03) || (op == 7'h23);
        br = (op == 7'h63);
        st = (op == 7'h23);
        e = '{is_trap: 1'b0, cause: 2'b00, lat: 0, wb: 1'b0, cnt: '0};
        if (fw >= TO) begin
            e.is_trap = 1'b1; e.cause = 2'b10; e.lat = TO + 1;
        end else if (!in_legal(op)) begin
            e.is_trap = 1'b1; e.cause = 2'b01; e.lat = fw + 3;
        end else if (ls && mw >= TO) begin
            e.is_trap = 1'b1; e.cause = 2'b11; e.lat = fw + TO + 4;
        end else begin
            if (br)      e.lat = fw + 3;
            else if (st) e.lat = fw + mw + 4;
            else if (ls) e.lat = fw + mw + 5;
            else         e.lat = fw + 4;
            e.wb = !(br || st);
            model_cnt = (model_cnt + 1) % (1 << CW);
            e.cnt = CW'(model_cnt);
        end
        sb.push_back(e);

        opcode = op;
        fc = 0; mc = 0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (mem_req && !addr_sel) begin
                mem_ready = (fc == fw); fc++;
            end else if (mem_req && addr_sel) begin
                mem_ready = (mc == mw); mc++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (retire || trap) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL instr_timeout: op %0h never retired or trapped", op);
            sb.delete();
        end
        if (trap || !done) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                mem_ready = 1'($urandom_range(0, 1));
            end
            do_reset();
        end
    endtask

    // Reset while a store sees mem_ready: nothing may be counted
    task automatic abort_in_mem();
        bit found = 1'b0;
        opcode = 7'h23;
        for (int c = 0; c < 50 && !found; c++) begin
            @(negedge clk);
            if (mem_req && addr_sel) begin
                mem_ready = 1'b1; rst = 1'b1; found = 1'b1;
            end else begin
                mem_ready = mem_req;
            end
        end
        chk("abort_reached_mem", found, 1);
        @(posedge clk);
        #1;
        chk("abort_state", state, 0);
        chk("abort_instret", instret, 0);
        chk("abort_quiet", {trap, mem_we, addr_sel}, 0);
        model_cnt = 0;
        rst = 1'b0;
    endtask

    // Monitor: per-cycle invariants plus scoreboard pop on retire / trap entry
    initial begin
        exp_t          e;
        bit            tseen = 1'b0;
        bit            ipend = 1'b0;
        logic [1:0]    hcause = 2'b00;
        logic [CW-1:0] icnt = '0;
        int            cyc = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                cyc = 0; tseen = 1'b0; ipend = 1'b0;
                continue;
            end
            cyc++;
            if (ipend) begin
                chk("instret", instret, icnt);
                ipend = 1'b0;
            end
            if (ir_we)  chk("ir_we_in_fetch", state, 0);
            if (mem_we) chk("mem_we_in_mem", state, 3);
            if (reg_we) chk("reg_we_in_wb", state, 4);
            if (pc_we || retire) chk("pc_we_with_retire", pc_we, retire);
            if (tseen) begin
                chk("trap_held", {trap, trap_cause, state}, {1'b1, hcause, 3'd7});
                chk("trap_quiet", {mem_req, mem_we, ir_we, pc_we, reg_we, retire}, 0);
            end else if (retire || trap) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: retire %0b trap %0b with empty scoreboard", retire, trap);
                end else begin
                    e = sb.pop_front();
                    chk("event_kind", trap, e.is_trap);
                    chk("latency", cyc, e.lat);
                    if (trap) begin
                        chk("trap_cause", trap_cause, e.cause);
                        chk("trap_state", state, 7);
                        tseen = 1'b1;
                        hcause = trap_cause;
                    end else begin
                        chk("reg_we_at_retire", reg_we, e.wb);
                        ipend = 1'b1;
                        icnt = e.cnt;
                    end
                end
                cyc = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] op;
        int         r, fw, mw;
        do_reset();
        chk("reset_fetch_req", {mem_req, addr_sel, mem_we, ir_we}, 4'b1000);

        run_instr(7'h33, 0, 0);    // ALU, zero wait
        run_instr(7'h03, 0, 3);    // load, 3 wait cycles in MEM
        run_instr(7'h23, 0, 0);    // store
        run_instr(7'h63, 2, 0);    // branch with fetch wait
        run_instr(7'h00, 0, 0);    // illegal opcode
        run_instr(7'h33, TO, 0);   // fetch timeout
        run_instr(7'h33, TO - 1, 0); // ready on the last allowed cycle
        run_instr(7'h03, 0, TO - 1);
        run_instr(7'h23, 0, TO);   // data timeout
        abort_in_mem();
        for (int i = 0; i < 17; i++) run_instr(7'h63, 0, 0); // counter wrap

        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 11);
            if (r < 9) begin
                op = legal[r];
            end else begin
                op = 7'($urandom_range(0, 127));
                while (in_legal(op)) op = 7'($urandom_range(0, 127));
            end
            r = $urandom_range(0, 29);
            fw = (r == 0) ? TO : (r == 1) ? TO - 1 : $urandom_range(0, 3);
            r = $urandom_range(0, 29);
            mw = (r == 0) ? TO : (r == 1) ? TO - 1 : $urandom_range(0, 3);
            run_instr(op, fw, mw);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
